// File: rtl/calc_display_pkg.sv
// calc_display_pkg
//   Shared definitions for the calculator display stage: converter FSM state
//   encodings, active-low 7-segment constants ({g,f,e,d,c,b,a}) and the
//   double-dabble add-3 helper.
package calc_display_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LATCH = 2'd2
    } cd_state_t;

    // Active-low segment codes, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_D0    = 7'b1000000;
    localparam logic [6:0] SEG_D1    = 7'b1111001;
    localparam logic [6:0] SEG_D2    = 7'b0100100;
    localparam logic [6:0] SEG_D3    = 7'b0110000;
    localparam logic [6:0] SEG_D4    = 7'b0011001;
    localparam logic [6:0] SEG_D5    = 7'b0010010;
    localparam logic [6:0] SEG_D6    = 7'b0000010;
    localparam logic [6:0] SEG_D7    = 7'b1111000;
    localparam logic [6:0] SEG_D8    = 7'b0000000;
    localparam logic [6:0] SEG_D9    = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_R     = 7'b0101111;

    // Double-dabble correction: any BCD nibble >= 5 gets +3 before the shift
    // so it carries correctly into the next decade.
    function automatic logic [11:0] dd_adjust(input logic [11:0] s);
        logic [11:0] r;
        r = s;
        for (int i = 0; i < 3; i++) begin
            if (s[i*4 +: 4] >= 4'd5)
                r[i*4 +: 4] = s[i*4 +: 4] + 4'd3;
        end
        return r;
    endfunction

endpackage

// File: rtl/calc_display_if.sv
// calc_display_if
//   Bundles the calculator-facing and display-facing signals of calc_display.
//     value [7:0]  unsigned result from the calculator
//     err          error/overflow flag
//     bcd  [11:0]  latched BCD {hundreds, tens, ones}
//     an   [3:0]   digit anodes, active-low, an[0] rightmost
//     seg  [6:0]   segments, active-low, {g,f,e,d,c,b,a}
//     dp           decimal point, active-low (always off)
//   master: the environment driving value/err; slave: calc_display itself.
interface calc_display_if;
    logic [7:0]  value;
    logic        err;
    logic [11:0] bcd;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    modport master (output value, err, input bcd, an, seg, dp);
    modport slave  (input value, err, output bcd, an, seg, dp);
endinterface

// File: rtl/calc_display_seg7_decoder.sv
// seg7_decoder
//   Combinational nibble to active-low 7-segment decoder with overrides.
//     nibble [3:0]  BCD digit to show (values above 9 render blank)
//     blank         force all segments off (highest priority)
//     show_e        render 'E'
//     show_r        render 'r'
//     seg [6:0]     active-low segments {g,f,e,d,c,b,a}
module seg7_decoder
    import calc_display_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       blank,
    input  logic       show_e,
    input  logic       show_r,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (blank) begin
            seg = SEG_BLANK;
        end else if (show_e) begin
            seg = SEG_E;
        end else if (show_r) begin
            seg = SEG_R;
        end else begin
            case (nibble)
                4'd0:    seg = SEG_D0;
                4'd1:    seg = SEG_D1;
                4'd2:    seg = SEG_D2;
                4'd3:    seg = SEG_D3;
                4'd4:    seg = SEG_D4;
                4'd5:    seg = SEG_D5;
                4'd6:    seg = SEG_D6;
                4'd7:    seg = SEG_D7;
                4'd8:    seg = SEG_D8;
                4'd9:    seg = SEG_D9;
                default: seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/calc_display.sv
// calc_display
//   Display stage for the 4-bit calculator. A free-running double-dabble FSM
//   (IDLE -> 8x SHIFT -> LATCH, 10-cycle period) converts the 8-bit result to
//   three BCD digits; a refresh counter scans a 4-digit active-low multiplexed
//   7-segment display with leading-zero blanking, or "Err" when err was set.
//   Ports:
//     clk         system clock
//     rst         synchronous active-high reset
//     bus.value   input value, sampled only in IDLE
//     bus.err     error flag, sampled only in IDLE
//     bus.bcd     latched BCD of the last conversion
//     bus.an      registered digit anodes (active-low)
//     bus.seg     registered segments (active-low)
//     bus.dp      decimal point, constant off
module calc_display
    import calc_display_pkg::*;
#(
    parameter int REFRESH_BITS = 16
) (
    input  logic         clk,
    input  logic         rst,
    calc_display_if.slave bus
);

    localparam logic [REFRESH_BITS-1:0] REFRESH_ONE = REFRESH_BITS'(1);

    cd_state_t         state;
    logic [7:0]        shift_reg;
    logic [11:0]       scratch;
    logic [2:0]        bit_cnt;
    logic              err_s;
    logic              err_q;
    logic [11:0]       bcd_q;

    logic [REFRESH_BITS-1:0] refresh_cnt;
    logic [1:0]        idx;

    logic [3:0]        dig_nib;
    logic              dig_blank;
    logic              dig_e;
    logic              dig_r;
    logic [6:0]        dec_seg;
    logic [3:0]        an_q;
    logic [6:0]        seg_q;

    // ---------------- converter FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            shift_reg <= 8'd0;
            scratch   <= 12'd0;
            bit_cnt   <= 3'd0;
            err_s     <= 1'b0;
            err_q     <= 1'b0;
            bcd_q     <= 12'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    shift_reg <= bus.value;
                    err_s     <= bus.err;
                    scratch   <= 12'd0;
                    bit_cnt   <= 3'd0;
                    state     <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    // correct first, then shift the whole 20-bit chain left
                    {scratch, shift_reg} <= {dd_adjust(scratch), shift_reg} << 1;
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7)
                        state <= ST_LATCH;
                end
                ST_LATCH: begin
                    bcd_q <= scratch;
                    err_q <= err_s;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // ---------------- scan counter ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            refresh_cnt <= '0;
            idx         <= 2'd0;
        end else begin
            refresh_cnt <= refresh_cnt + REFRESH_ONE;
            if (refresh_cnt == '1)
                idx <= idx + 2'd1;
        end
    end

    // ---------------- digit select ----------------
    // Leading-zero blanking: tens is only blank when hundreds is also zero,
    // the ones digit always shows.
    always_comb begin
        dig_nib   = 4'd0;
        dig_blank = 1'b1;
        dig_e     = 1'b0;
        dig_r     = 1'b0;
        if (err_q) begin
            case (idx)
                2'd2: begin dig_blank = 1'b0; dig_e = 1'b1; end
                2'd1,
                2'd0: begin dig_blank = 1'b0; dig_r = 1'b1; end
                default: dig_blank = 1'b1;
            endcase
        end else begin
            case (idx)
                2'd0: begin
                    dig_nib   = bcd_q[3:0];
                    dig_blank = 1'b0;
                end
                2'd1: begin
                    dig_nib   = bcd_q[7:4];
                    dig_blank = (bcd_q[11:8] == 4'd0) && (bcd_q[7:4] == 4'd0);
                end
                2'd2: begin
                    dig_nib   = bcd_q[11:8];
                    dig_blank = (bcd_q[11:8] == 4'd0);
                end
                default: dig_blank = 1'b1;
            endcase
        end
    end

    seg7_decoder u_dec (
        .nibble (dig_nib),
        .blank  (dig_blank),
        .show_e (dig_e),
        .show_r (dig_r),
        .seg    (dec_seg)
    );

    // ---------------- output registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            an_q  <= 4'hF;
            seg_q <= SEG_BLANK;
        end else begin
            an_q  <= ~(4'b0001 << idx);
            seg_q <= dec_seg;
        end
    end

    assign bus.bcd = bcd_q;
    assign bus.an  = an_q;
    assign bus.seg = seg_q;
    assign bus.dp  = 1'b1;

endmodule

// File: tb/tb_calc_display.sv
// tb_calc_display
//   Directed self-checking bench for calc_display with REFRESH_BITS=2.
//   Stimulus changes on the falling edge; outputs are sampled on the falling
//   edge, half a cycle away from the active rising edge.
module tb_calc_display;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;

    calc_display_if bus();

    calc_display #(.REFRESH_BITS(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    localparam logic [6:0] S_BLK = 7'b1111111;
    localparam logic [6:0] S_0   = 7'b1000000;
    localparam logic [6:0] S_2   = 7'b0100100;
    localparam logic [6:0] S_4   = 7'b0011001;
    localparam logic [6:0] S_5   = 7'b0010010;
    localparam logic [6:0] S_7   = 7'b1111000;
    localparam logic [6:0] S_E   = 7'b0000110;
    localparam logic [6:0] S_R   = 7'b0101111;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Wait (bounded) until the given anode is active, then check its segments.
    task automatic wait_an(input string tag, input logic [3:0] target, input logic [6:0] exp_seg);
        bit found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (bus.an === target) found = 1;
            else @(negedge clk);
        end
        if (found) chk(tag, 32'(bus.seg), 32'(exp_seg));
        else       chk({tag, "_an"}, 32'(bus.an), 32'(target));
    endtask

    // Wait (bounded) for bcd to take a value; returns on the negedge right
    // after the LATCH edge that produced it.
    task automatic wait_bcd(input string tag, input logic [11:0] exp);
        bit found = 0;
        for (int i = 0; i < 25 && !found; i++) begin
            @(negedge clk);
            if (bus.bcd === exp) found = 1;
        end
        chk(tag, 32'(bus.bcd), 32'(exp));
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_an"},  32'(bus.an),  32'h0000000F);
        chk({tag, "_seg"}, 32'(bus.seg), 32'(S_BLK));
        chk({tag, "_dp"},  32'(bus.dp),  32'h1);
        chk({tag, "_bcd"}, 32'(bus.bcd), 32'h000);
    endtask

    initial begin
        rst       = 1'b1;
        bus.value = 8'd99;
        bus.err   = 1'b0;

        // 1. reset held 3 cycles
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_reset_outs("rst_hold");
        end

        // 2. value 255; capture at edge 1, bcd at edge 10
        bus.value = 8'd255;
        rst = 1'b0;
        @(negedge clk);
        chk("first_an",  32'(bus.an),  32'h0000000E);
        chk("first_seg", 32'(bus.seg), 32'(S_0));
        repeat (8) @(negedge clk);
        chk("bcd255_pre", 32'(bus.bcd), 32'h000);
        @(negedge clk);
        chk("bcd255", 32'(bus.bcd), 32'h255);
        @(negedge clk);
        wait_an("255_d0", 4'b1110, S_5);
        wait_an("255_d1", 4'b1101, S_5);
        wait_an("255_d2", 4'b1011, S_2);
        wait_an("255_d3", 4'b0111, S_BLK);

        // 3. value 7: leading zeros blanked
        bus.value = 8'd7;
        repeat (22) @(negedge clk);
        chk("bcd7", 32'(bus.bcd), 32'h007);
        wait_an("7_d0", 4'b1110, S_7);
        wait_an("7_d1", 4'b1101, S_BLK);
        wait_an("7_d2", 4'b1011, S_BLK);
        wait_an("7_d3", 4'b0111, S_BLK);

        // 4. value 0: ones digit still shows 0
        bus.value = 8'd0;
        repeat (22) @(negedge clk);
        chk("bcd0", 32'(bus.bcd), 32'h000);
        wait_an("0_d0", 4'b1110, S_0);
        wait_an("0_d1", 4'b1101, S_BLK);
        wait_an("0_d2", 4'b1011, S_BLK);

        // 5. value changes mid-SHIFT; align to a LATCH edge first
        bus.value = 8'd9;
        wait_bcd("bcd9", 12'h009);
        bus.value = 8'd100;               // captured at the next (IDLE) edge
        repeat (3) @(negedge clk);
        bus.value = 8'd42;                // inside SHIFT, ignored this round
        repeat (6) @(negedge clk);
        chk("bcd100_pre", 32'(bus.bcd), 32'h009);
        @(negedge clk);
        chk("bcd100", 32'(bus.bcd), 32'h100);
        repeat (9) @(negedge clk);
        chk("bcd42_pre", 32'(bus.bcd), 32'h100);
        @(negedge clk);
        chk("bcd42", 32'(bus.bcd), 32'h042);
        @(negedge clk);
        wait_an("42_d1", 4'b1101, S_4);
        wait_an("42_d2", 4'b1011, S_BLK);
        wait_an("42_d0", 4'b1110, S_2);

        // 6. error display
        bus.err   = 1'b1;
        bus.value = 8'd200;
        repeat (22) @(negedge clk);
        chk("bcd200", 32'(bus.bcd), 32'h200);
        wait_an("err_d3", 4'b0111, S_BLK);
        wait_an("err_d2", 4'b1011, S_E);
        wait_an("err_d1", 4'b1101, S_R);
        wait_an("err_d0", 4'b1110, S_R);

        // reset pulsed during SHIFT
        bus.value = 8'd201;
        wait_bcd("bcd201", 12'h201);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_reset_outs("rst_mid");
        bus.value = 8'd55;
        bus.err   = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        chk("restart_an",  32'(bus.an),  32'h0000000E);
        chk("restart_seg", 32'(bus.seg), 32'(S_0));
        repeat (8) @(negedge clk);
        chk("bcd55_pre", 32'(bus.bcd), 32'h000);
        @(negedge clk);
        chk("bcd55", 32'(bus.bcd), 32'h055);
        @(negedge clk);
        wait_an("55_d1", 4'b1101, S_5);
        wait_an("55_d2", 4'b1011, S_BLK);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
